run_monitor: RTL and testbench
==============================

# run_monitor

Synthesizable run controller and result-drain engine for the matrix/vector accelerator. It tracks a program run against an instruction count, detects completion across a parametrised number of busy channels, counts run cycles and enforces a watchdog timeout. On completion it streams the output memory out over a valid/ready port. It sits beside `top`, observing `u_instruction_memory.program_counter` and the per-unit instruction-valid flags, and owns a read port on `u_output_mem`.

## Interface
- IMEM_ADDR_WIDTH, `IMEM_ADDR_WIDTH: program counter / instruction count width
- NUM_CH, 2: number of busy channels (PE, buffer, ...)
- CYCLE_WIDTH, 32: cycle counter and timeout width
- SETTLE_CYCLES, 1: consecutive idle cycles required to declare completion (>=1)
- OMEM_DEPTH, 64: output memory words to drain
- OMEM_ADDR_WIDTH, $clog2(OMEM_DEPTH): output memory address width
- OMEM_DATA_WIDTH, 32: output memory word width

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  run start pulse
- instruction_count  in  IMEM_ADDR_WIDTH  target PC, sampled on accepted start
- dump_en  in  1  drain output memory on completion, sampled on accepted start
- timeout_cycles  in  CYCLE_WIDTH  watchdog limit, sampled on accepted start; 0 = disabled
- program_counter  in  IMEM_ADDR_WIDTH  current instruction-memory PC
- ch_busy  in  NUM_CH  per-channel instruction-valid flags
- omem_rd_en  out  1  output memory read strobe
- omem_rd_addr  out  OMEM_ADDR_WIDTH  read address
- omem_rd_data  in  OMEM_DATA_WIDTH  read data, valid exactly 1 cycle after omem_rd_en
- dump_valid  out  1  drained word available
- dump_addr  out  OMEM_ADDR_WIDTH  address of dump_data
- dump_data  out  OMEM_DATA_WIDTH  drained word
- dump_ready  in  1  sink accepts word
- busy  out  1  state is RUN, SETTLE or DUMP
- done  out  1  run completed (and drained if dump_en); sticky
- timed_out  out  1  watchdog fired; sticky
- cycle_count  out  CYCLE_WIDTH  run length in cycles

## Operation
- States: IDLE, RUN, SETTLE, DUMP, DONE, TIMEOUT. Reset -> IDLE.
- start accepted only in IDLE, DONE, TIMEOUT; ignored otherwise. On accept: latch inputs, clear done/timed_out/cycle_count/settle counter, -> RUN.
- idle_cond = (program_counter == latched instruction_count) && (ch_busy == 0).
- RUN: idle_cond -> SETTLE with settle counter = 1; if SETTLE_CYCLES == 1 go directly to DUMP (dump_en) or DONE.
- SETTLE: idle_cond false -> RUN, counter cleared. Counter reaches SETTLE_CYCLES -> DUMP if dump_en else DONE.
- cycle_count increments every cycle in RUN/SETTLE, saturates at all-ones, frozen elsewhere.
- Watchdog: in RUN/SETTLE, timeout nonzero and cycle_count == timeout -> TIMEOUT, timed_out=1, no drain. If completion and timeout happen in the same cycle, completion wins.
- DUMP: reads addresses 0..OMEM_DEPTH-1 in order into a 2-entry output FIFO. A read is issued when FIFO occupancy + in-flight reads < 2. dump_valid = FIFO non-empty; a word transfers on dump_valid && dump_ready. After the word at OMEM_DEPTH-1 is accepted -> DONE, done=1.
- instruction_count 0 with PC 0 and all channels idle completes after SETTLE_CYCLES.

## Timing
- Reset values: omem_rd_en=0, omem_rd_addr=0, dump_valid=0, dump_addr=0, dump_data=0, busy=0, done=0, timed_out=0, cycle_count=0; FIFO empty, in-flight read dropped.
- Reset mid-run or mid-drain: IDLE the next cycle; no further reads or dump words.
- start at edge t: busy=1 from t+1, first cycle_count increment at t+1 -> value 1 at t+2.
- Completion latency: idle_cond first true at edge t -> leaves SETTLE at t+SETTLE_CYCLES.
- Read issued at t -> data in FIFO, dump_valid=1 at t+2 edge view (captured at t+1 edge).
- With dump_ready held high the drain sustains 1 word/cycle; total drain OMEM_DEPTH+2 cycles.
- dump_data/dump_addr stable while dump_valid && !dump_ready.
- busy falls and done rises on the same edge.

## Test plan
- NUM_CH=2, SETTLE=1, count=10, PC ramps 0..10 with ch_busy=0 at 10, dump_en=0 -> done=1, cycle_count = cycles to PC 10, no omem_rd_en.
- SETTLE=3, ch_busy[1] glitches high 1 cycle after PC match -> returns to RUN; done only after 3 clean idle cycles.
- timeout=20, PC stuck at 5 -> timed_out=1 at cycle_count 20, done=0, busy=0; start again restarts cleanly.
- dump_en=1, OMEM_DEPTH=8, mem[i]=i*3, dump_ready=1 -> 8 words 0,3,...,21 on consecutive cycles, addresses 0..7, then done.
- Same drain with dump_ready toggling randomly -> no loss or duplication, data held while stalled, FIFO never exceeds 2.
- rst_n low during DUMP at word 4 -> all outputs at reset values next cycle; a new start produces a full drain from address 0.

Source files
------------

// File: rtl/run_monitor_if.sv
// Result-drain bus of the run monitor: output-memory read port plus the
// valid/ready word stream. master = run_monitor, slave = memory/sink side.
interface run_monitor_if #(
    parameter int OMEM_ADDR_WIDTH = 6,
    parameter int OMEM_DATA_WIDTH = 32
);
    logic                       omem_rd_en;
    logic [OMEM_ADDR_WIDTH-1:0] omem_rd_addr;
    logic [OMEM_DATA_WIDTH-1:0] omem_rd_data;
    logic                       dump_valid;
    logic [OMEM_ADDR_WIDTH-1:0] dump_addr;
    logic [OMEM_DATA_WIDTH-1:0] dump_data;
    logic                       dump_ready;

    modport master (
        output omem_rd_en, omem_rd_addr,
        input  omem_rd_data,
        output dump_valid, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  omem_rd_en, omem_rd_addr,
        output omem_rd_data,
        input  dump_valid, dump_addr, dump_data,
        output dump_ready
    );
endinterface

// File: rtl/run_monitor.sv
// Run controller: tracks a program run to completion (PC reached and all
// channels idle for SETTLE_CYCLES), counts run cycles, enforces a watchdog,
// and optionally drains the output memory through a 2-entry FIFO.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif

module run_monitor #(
    parameter int IMEM_ADDR_WIDTH = `IMEM_ADDR_WIDTH,
    parameter int NUM_CH          = 2,
    parameter int CYCLE_WIDTH     = 32,
    parameter int SETTLE_CYCLES   = 1,
    parameter int OMEM_DEPTH      = 64,
    parameter int OMEM_ADDR_WIDTH = $clog2(OMEM_DEPTH),
    parameter int OMEM_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [IMEM_ADDR_WIDTH-1:0] instruction_count,
    input  logic                       dump_en,
    input  logic [CYCLE_WIDTH-1:0]     timeout_cycles,
    input  logic [IMEM_ADDR_WIDTH-1:0] program_counter,
    input  logic [NUM_CH-1:0]          ch_busy,
    run_monitor_if.master              bus,
    output logic                       busy,
    output logic                       done,
    output logic                       timed_out,
    output logic [CYCLE_WIDTH-1:0]     cycle_count
);
    localparam int                   SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam bit                   SETTLE_ONE  = (SETTLE_CYCLES == 1);
    localparam logic [OMEM_ADDR_WIDTH-1:0] LAST_ADDR = OMEM_ADDR_WIDTH'(OMEM_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_DUMP, S_DONE, S_TIMEOUT} state_t;

    state_t                     r_state;
    logic [IMEM_ADDR_WIDTH-1:0] r_icount;
    logic                       r_dump_en;
    logic [CYCLE_WIDTH-1:0]     r_timeout;
    logic [CYCLE_WIDTH-1:0]     r_cycle;
    logic [SW-1:0]              r_settle;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_timed_out;

    logic [OMEM_ADDR_WIDTH-1:0] r_rd_addr;
    logic                       r_issued_all;
    logic                       r_pend;
    logic [OMEM_ADDR_WIDTH-1:0] r_pend_addr;
    logic [OMEM_DATA_WIDTH-1:0] r_fifo_data [2];
    logic [OMEM_ADDR_WIDTH-1:0] r_fifo_addr [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_occ;

    logic       w_accept;
    logic       w_idle;
    logic       w_complete;
    logic       w_wd_hit;
    logic       w_pop;
    logic       w_last_pop;
    logic [2:0] w_used;
    logic       w_rd_en;

    assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_TIMEOUT);
    assign w_idle     = (program_counter == r_icount) && (ch_busy == '0);
    assign w_complete = w_idle && ((r_state == S_RUN && SETTLE_ONE) ||
                                   (r_state == S_SETTLE && r_settle >= SETTLE_LAST));
    assign w_wd_hit   = (r_timeout != '0) && (r_cycle == r_timeout);
    assign w_pop      = (r_occ != 2'd0) && bus.dump_ready;
    assign w_last_pop = w_pop && (r_fifo_addr[r_rd_ptr] == LAST_ADDR);
    // A slot freed by this cycle's pop is reusable immediately; without that
    // credit the 2-cycle read latency would halve drain throughput.
    assign w_used     = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_rd_en    = (r_state == S_DUMP) && !r_issued_all && (w_used < 3'd2);

    assign bus.omem_rd_en   = w_rd_en;
    assign bus.omem_rd_addr = r_rd_addr;
    assign bus.dump_valid   = (r_occ != 2'd0);
    assign bus.dump_addr    = r_fifo_addr[r_rd_ptr];
    assign bus.dump_data    = r_fifo_data[r_rd_ptr];
    assign busy             = r_busy;
    assign done             = r_done;
    assign timed_out        = r_timed_out;
    assign cycle_count      = r_cycle;

    // Run-control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_icount    <= '0;
            r_dump_en   <= 1'b0;
            r_timeout   <= '0;
            r_cycle     <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        r_icount    <= instruction_count;
                        r_dump_en   <= dump_en;
                        r_timeout   <= timeout_cycles;
                        r_cycle     <= '0;
                        r_settle    <= '0;
                        r_done      <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN, S_SETTLE: begin
                    if (w_complete) begin
                        if (!(&r_cycle)) r_cycle <= r_cycle + CYCLE_WIDTH'(1);
                        r_settle <= '0;
                        if (r_dump_en) begin
                            r_state <= S_DUMP;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_wd_hit) begin
                        r_state     <= S_TIMEOUT;
                        r_busy      <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        if (!(&r_cycle)) r_cycle <= r_cycle + CYCLE_WIDTH'(1);
                        if (!w_idle) begin
                            r_state  <= S_RUN;
                            r_settle <= '0;
                        end else if (r_state == S_RUN) begin
                            r_state  <= S_SETTLE;
                            r_settle <= SW'(1);
                        end else begin
                            r_settle <= r_settle + SW'(1);
                        end
                    end
                end
                S_DUMP: begin
                    if (w_last_pop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Drain datapath: read issue, in-flight tracking and the 2-entry FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_rd_addr    <= '0;
            r_issued_all <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_occ        <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else begin
            r_pend <= w_rd_en;
            if (w_rd_en) begin
                r_pend_addr <= r_rd_addr;
                r_rd_addr   <= r_rd_addr + OMEM_ADDR_WIDTH'(1);
                if (r_rd_addr == LAST_ADDR) r_issued_all <= 1'b1;
            end
            if (r_pend) begin
                r_fifo_data[r_wr_ptr] <= bus.omem_rd_data;
                r_fifo_addr[r_wr_ptr] <= r_pend_addr;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: two instances (SETTLE_CYCLES 1 and 3,
// OMEM_DEPTH 8) with a synchronous-read memory model holding mem[i] = 3*i.
module tb_run_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic [7:0]  instruction_count;
    logic        dump_en;
    logic [31:0] timeout_cycles;
    logic [7:0]  program_counter;
    logic [1:0]  ch_busy;
    logic        dump_ready;
    logic        busy1, done1, to1, busy3, done3, to3;
    logic [31:0] cyc1, cyc3;
    int          rd_cnt1 = 0;
    int          checks = 0;
    int          errors = 0;

    run_monitor_if #(.OMEM_ADDR_WIDTH(3), .OMEM_DATA_WIDTH(32)) if1 ();
    run_monitor_if #(.OMEM_ADDR_WIDTH(3), .OMEM_DATA_WIDTH(32)) if3 ();

    assign if1.dump_ready = dump_ready;
    assign if3.dump_ready = dump_ready;

    run_monitor #(.IMEM_ADDR_WIDTH(8), .NUM_CH(2), .CYCLE_WIDTH(32), .SETTLE_CYCLES(1),
                  .OMEM_DEPTH(8), .OMEM_ADDR_WIDTH(3), .OMEM_DATA_WIDTH(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .instruction_count(instruction_count),
        .dump_en(dump_en), .timeout_cycles(timeout_cycles), .program_counter(program_counter),
        .ch_busy(ch_busy), .bus(if1), .busy(busy1), .done(done1), .timed_out(to1),
        .cycle_count(cyc1));

    run_monitor #(.IMEM_ADDR_WIDTH(8), .NUM_CH(2), .CYCLE_WIDTH(32), .SETTLE_CYCLES(3),
                  .OMEM_DEPTH(8), .OMEM_ADDR_WIDTH(3), .OMEM_DATA_WIDTH(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .instruction_count(instruction_count),
        .dump_en(dump_en), .timeout_cycles(timeout_cycles), .program_counter(program_counter),
        .ch_busy(ch_busy), .bus(if3), .busy(busy3), .done(done3), .timed_out(to3),
        .cycle_count(cyc3));

    always #5 clk = ~clk;

    // Output memory models: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (if1.omem_rd_en) begin
            if1.omem_rd_data <= 32'(if1.omem_rd_addr) * 32'd3;
            rd_cnt1 <= rd_cnt1 + 1;
        end
        if (if3.omem_rd_en) if3.omem_rd_data <= 32'(if3.omem_rd_addr) * 32'd3;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        instruction_count = 8'd0; dump_en = 1'b0; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b00; dump_ready = 1'b0;
        do_reset();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done1); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL reset_timed_out: got %0d expected 0", to1); end
        checks++; if (cyc1 !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cyc1); end
        checks++; if (if1.omem_rd_en !== 1'b0 || if1.omem_rd_addr !== 3'd0) begin
            errors++; $display("FAIL reset_rd: got en %0d addr %0d expected 0 0", if1.omem_rd_en, if1.omem_rd_addr); end
        checks++; if (if1.dump_valid !== 1'b0 || if1.dump_addr !== 3'd0 || if1.dump_data !== 32'd0) begin
            errors++; $display("FAIL reset_dump: got v %0d a %0d d %0d expected 0 0 0", if1.dump_valid, if1.dump_addr, if1.dump_data); end
    endtask

    task automatic test_complete;
        int base;
        do_reset();
        base = rd_cnt1;
        instruction_count = 8'd10; dump_en = 1'b0; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b01;
        start1 = 1'b1; tick(); start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || cyc1 !== 32'd0) begin
            errors++; $display("FAIL start_state: got busy %0d cyc %0d expected 1 0", busy1, cyc1); end
        for (int k = 1; k <= 10; k++) begin
            program_counter = 8'(k);
            ch_busy = (k == 10) ? 2'b00 : 2'b01;
            tick();
            if (k == 1) begin
                checks++; if (cyc1 !== 32'd1) begin errors++; $display("FAIL first_increment: got %0d expected 1", cyc1); end
            end
            if (k == 9) begin
                checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin
                    errors++; $display("FAIL early_done: got done %0d busy %0d expected 0 1", done1, busy1); end
            end
        end
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL complete: got done %0d busy %0d expected 1 0", done1, busy1); end
        checks++; if (cyc1 !== 32'd10) begin errors++; $display("FAIL complete_cycles: got %0d expected 10", cyc1); end
        tick(); tick();
        checks++; if (cyc1 !== 32'd10 || done1 !== 1'b1) begin
            errors++; $display("FAIL frozen: got cyc %0d done %0d expected 10 1", cyc1, done1); end
        checks++; if (rd_cnt1 - base !== 0) begin errors++; $display("FAIL no_reads: got %0d expected 0", rd_cnt1 - base); end
    endtask

    task automatic test_settle;
        do_reset();
        instruction_count = 8'd10; dump_en = 1'b0; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b01;
        start3 = 1'b1; tick(); start3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            program_counter = 8'(k);
            ch_busy = (k == 10) ? 2'b00 : 2'b01;
            tick();
        end
        checks++; if (done3 !== 1'b0 || busy3 !== 1'b1) begin
            errors++; $display("FAIL settle_enter: got done %0d busy %0d expected 0 1", done3, busy3); end
        ch_busy = 2'b10; tick();
        checks++; if (done3 !== 1'b0 || busy3 !== 1'b1) begin
            errors++; $display("FAIL settle_glitch: got done %0d busy %0d expected 0 1", done3, busy3); end
        ch_busy = 2'b00; tick(); tick();
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL settle_two_idle: got %0d expected 0", done3); end
        tick();
        checks++; if (done3 !== 1'b1 || busy3 !== 1'b0) begin
            errors++; $display("FAIL settle_done: got done %0d busy %0d expected 1 0", done3, busy3); end
        checks++; if (cyc3 !== 32'd14) begin errors++; $display("FAIL settle_cycles: got %0d expected 14", cyc3); end
    endtask

    task automatic test_timeout;
        do_reset();
        instruction_count = 8'd10; dump_en = 1'b0; timeout_cycles = 32'd20;
        program_counter = 8'd5; ch_busy = 2'b00;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (to1 !== 1'b0 || busy1 !== 1'b1 || cyc1 !== 32'd20) begin
            errors++; $display("FAIL pre_timeout: got to %0d busy %0d cyc %0d expected 0 1 20", to1, busy1, cyc1); end
        tick();
        checks++; if (to1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL timeout: got to %0d busy %0d done %0d expected 1 0 0", to1, busy1, done1); end
        tick();
        checks++; if (cyc1 !== 32'd20) begin errors++; $display("FAIL timeout_cycles: got %0d expected 20", cyc1); end
        timeout_cycles = 32'd0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        checks++; if (to1 !== 1'b0 || busy1 !== 1'b1 || cyc1 !== 32'd0) begin
            errors++; $display("FAIL restart: got to %0d busy %0d cyc %0d expected 0 1 0", to1, busy1, cyc1); end
        program_counter = 8'd10; tick();
        checks++; if (done1 !== 1'b1 || cyc1 !== 32'd1) begin
            errors++; $display("FAIL restart_done: got done %0d cyc %0d expected 1 1", done1, cyc1); end
    endtask

    // Full drain with dump_ready high; DUT must be idle/done on entry.
    task automatic test_drain;
        int base;
        base = rd_cnt1;
        instruction_count = 8'd0; dump_en = 1'b1; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b00; dump_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || cyc1 !== 32'd1) begin
            errors++; $display("FAIL drain_enter: got busy %0d done %0d cyc %0d expected 1 0 1", busy1, done1, cyc1); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (c < 2) begin
                if (if1.dump_valid !== 1'b0) begin errors++; $display("FAIL drain_latency c%0d: got valid %0d expected 0", c, if1.dump_valid); end
            end else if (if1.dump_valid !== 1'b1 || if1.dump_addr !== 3'(c - 2) || if1.dump_data !== 32'((c - 2) * 3)) begin
                errors++; $display("FAIL drain_word c%0d: got v %0d a %0d d %0d expected 1 %0d %0d",
                                   c, if1.dump_valid, if1.dump_addr, if1.dump_data, c - 2, (c - 2) * 3);
            end
            tick();
        end
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || if1.dump_valid !== 1'b0) begin
            errors++; $display("FAIL drain_done: got done %0d busy %0d valid %0d expected 1 0 0", done1, busy1, if1.dump_valid); end
        checks++; if (rd_cnt1 - base !== 8) begin errors++; $display("FAIL drain_reads: got %0d expected 8", rd_cnt1 - base); end
    endtask

    task automatic test_backpressure;
        logic [15:0] pat;
        logic [2:0]  hold_a;
        logic [31:0] hold_d;
        logic        hold_v;
        int          idx, base, k;
        pat = 16'b1011_0010_0110_0101;
        do_reset();
        base = rd_cnt1;
        instruction_count = 8'd0; dump_en = 1'b1; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b00; dump_ready = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        idx = 0; hold_v = 1'b0; hold_a = '0; hold_d = '0; k = 0;
        while (done1 !== 1'b1 && k < 80) begin
            dump_ready = pat[k % 16];
            if (hold_v) begin
                checks++;
                if (if1.dump_valid !== 1'b1 || if1.dump_addr !== hold_a || if1.dump_data !== hold_d) begin
                    errors++; $display("FAIL bp_hold k%0d: got v %0d a %0d d %0d expected 1 %0d %0d",
                                       k, if1.dump_valid, if1.dump_addr, if1.dump_data, hold_a, hold_d); end
            end
            checks++; if (rd_cnt1 - base - idx > 2) begin
                errors++; $display("FAIL bp_occupancy k%0d: got %0d expected <=2", k, rd_cnt1 - base - idx); end
            hold_v = if1.dump_valid && !dump_ready;
            hold_a = if1.dump_addr;
            hold_d = if1.dump_data;
            if (if1.dump_valid === 1'b1 && dump_ready) begin
                checks++;
                if (if1.dump_addr !== 3'(idx) || if1.dump_data !== 32'(idx * 3)) begin
                    errors++; $display("FAIL bp_word %0d: got a %0d d %0d expected %0d %0d",
                                       idx, if1.dump_addr, if1.dump_data, idx, idx * 3); end
                idx++;
            end
            tick();
            k++;
        end
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL bp_done: got %0d expected 1 within 80 cycles", done1); end
        checks++; if (idx !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", idx); end
        checks++; if (rd_cnt1 - base !== 8) begin errors++; $display("FAIL bp_reads: got %0d expected 8", rd_cnt1 - base); end
        dump_ready = 1'b1;
    endtask

    task automatic test_reset_mid_drain;
        int snap, k;
        do_reset();
        instruction_count = 8'd0; dump_en = 1'b1; timeout_cycles = 32'd0;
        program_counter = 8'd0; ch_busy = 2'b00; dump_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        k = 0;
        while (!(if1.dump_valid === 1'b1 && if1.dump_addr === 3'd4) && k < 20) begin tick(); k++; end
        checks++; if (if1.dump_addr !== 3'd4) begin errors++; $display("FAIL mid_reach: got %0d expected 4", if1.dump_addr); end
        rst_n = 1'b0; tick();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || to1 !== 1'b0 || cyc1 !== 32'd0) begin
            errors++; $display("FAIL mid_reset_status: got busy %0d done %0d to %0d cyc %0d expected 0 0 0 0", busy1, done1, to1, cyc1); end
        checks++; if (if1.omem_rd_en !== 1'b0 || if1.omem_rd_addr !== 3'd0 || if1.dump_valid !== 1'b0 ||
                      if1.dump_addr !== 3'd0 || if1.dump_data !== 32'd0) begin
            errors++; $display("FAIL mid_reset_bus: got en %0d ra %0d v %0d a %0d d %0d expected 0 0 0 0 0",
                               if1.omem_rd_en, if1.omem_rd_addr, if1.dump_valid, if1.dump_addr, if1.dump_data); end
        snap = rd_cnt1;
        rst_n = 1'b1; tick(); tick();
        checks++; if (rd_cnt1 !== snap || if1.dump_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_quiet: got reads %0d valid %0d expected 0 0", rd_cnt1 - snap, if1.dump_valid); end
        test_drain();
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        test_reset();
        test_complete();
        test_settle();
        test_timeout();
        do_reset();
        test_drain();
        test_backpressure();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
